// File: rtl/mem_fetch_ctrl_if.sv
// Bus bundle between mem_fetch_ctrl and its surroundings (memory, decode, execute).
//   master : the fetch controller (drives o_* signals, receives i_* signals)
//   slave  : the environment (memory model, decode stage, execute stage)
interface mem_fetch_ctrl_if #(
    parameter int unsigned BITS = 16
) ();

    // Memory port
    logic            o_mem_rw;
    logic [7:0]      o_mem_addr;
    logic [BITS-1:0] o_mem_wdata;
    logic [BITS-1:0] i_mem_rdata;

    // Instruction stream to decode
    logic            o_ins_valid;
    logic [BITS-1:0] o_ins_data;
    logic [7:0]      o_ins_pc;
    logic            i_ins_ready;

    // Redirect
    logic            i_jmp_valid;
    logic [7:0]      i_jmp_addr;

    // Data access from execute
    logic            i_dreq_valid;
    logic            i_dreq_rw;
    logic [7:0]      i_dreq_addr;
    logic [BITS-1:0] i_dreq_wdata;
    logic            o_dreq_ready;
    logic            o_drsp_valid;
    logic [BITS-1:0] o_drsp_data;

    modport master (
        output o_mem_rw, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata,
        output o_ins_valid, o_ins_data, o_ins_pc,
        input  i_ins_ready,
        input  i_jmp_valid, i_jmp_addr,
        input  i_dreq_valid, i_dreq_rw, i_dreq_addr, i_dreq_wdata,
        output o_dreq_ready, o_drsp_valid, o_drsp_data
    );

    modport slave (
        input  o_mem_rw, o_mem_addr, o_mem_wdata,
        output i_mem_rdata,
        input  o_ins_valid, o_ins_data, o_ins_pc,
        output i_ins_ready,
        output i_jmp_valid, i_jmp_addr,
        output i_dreq_valid, i_dreq_rw, i_dreq_addr, i_dreq_wdata,
        input  o_dreq_ready, o_drsp_valid, o_drsp_data
    );

endinterface

// File: rtl/mem_fetch_ctrl.sv
// Sole master of a single-port 256-word memory. Each cycle the port goes to an
// execute-stage data access if one is requested, otherwise to sequential
// instruction prefetch when the prefetch FIFO has room. Prefetched words are
// handed to decode through a valid/ready handshake at the FIFO head.
// Ports:
//   i_clk  : clock, all state changes on the rising edge
//   i_rst  : synchronous reset, active-high
//   bus    : mem_fetch_ctrl_if.master -- memory port (o_mem_*/i_mem_rdata),
//            instruction stream (o_ins_*/i_ins_ready), redirect (i_jmp_*),
//            data request/response (i_dreq_*/o_dreq_ready/o_drsp_*)
// The memory port outputs are combinational because the memory reads
// combinationally from the address presented in the same cycle.
module mem_fetch_ctrl #(
    parameter int unsigned BITS       = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  RESET_PC   = 8'h00
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mem_fetch_ctrl_if.master bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [7:0]      fetch_pc_q,   fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic            drsp_valid_q, drsp_valid_d;
    logic [BITS-1:0] drsp_data_q,  drsp_data_d;

    logic [7:0]      fifo_pc_q   [FIFO_DEPTH];
    logic [BITS-1:0] fifo_data_q [FIFO_DEPTH];

    logic            ins_valid_c;
    logic            pop_c;
    logic            can_accept_c;
    logic            data_cyc_c;
    logic            fetch_cyc_c;
    logic            push_c;

    logic            mem_rw_c;
    logic [7:0]      mem_addr_c;
    logic [BITS-1:0] mem_wdata_c;

    // Handshake and arbitration decisions for this cycle
    always_comb begin
        ins_valid_c  = (count_q != '0);
        pop_c        = ins_valid_c & bus.i_ins_ready;
        // A full FIFO still accepts when its head leaves in the same cycle
        can_accept_c = (count_q < CNT_W'(FIFO_DEPTH)) | pop_c;
        data_cyc_c   = bus.i_dreq_valid;
        fetch_cyc_c  = ~data_cyc_c & can_accept_c;
        // A fetch issued in a redirect cycle belongs to the old stream
        push_c       = fetch_cyc_c & ~bus.i_jmp_valid;
    end

    // Memory port drive; idle port parks on fetch_pc
    always_comb begin
        mem_rw_c    = 1'b0;
        mem_addr_c  = fetch_pc_q;
        mem_wdata_c = '0;
        if (i_rst) begin
            mem_addr_c = 8'h00;
        end else if (data_cyc_c) begin
            mem_addr_c = bus.i_dreq_addr;
            mem_rw_c   = bus.i_dreq_rw;
            if (bus.i_dreq_rw) begin
                mem_wdata_c = bus.i_dreq_wdata;
            end
        end
    end

    // Next-state for fetch pointer, FIFO bookkeeping and load response
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        drsp_valid_d = 1'b0;
        drsp_data_d  = drsp_data_q;

        if (bus.i_jmp_valid) begin
            // Flush dominates any same-cycle push or pop
            fetch_pc_d = bus.i_jmp_addr;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 8'd1;
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push_c && pop_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        if (data_cyc_c && !bus.i_dreq_rw) begin
            drsp_valid_d = 1'b1;
            drsp_data_d  = bus.i_mem_rdata;
        end
    end

    // Control state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q   <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            drsp_valid_q <= 1'b0;
            drsp_data_q  <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            drsp_valid_q <= drsp_valid_d;
            drsp_data_q  <= drsp_data_d;
        end
    end

    // FIFO storage; contents only matter while counted, so no reset
    always_ff @(posedge i_clk) begin
        if (!i_rst && push_c) begin
            fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
            fifo_data_q[wr_ptr_q] <= bus.i_mem_rdata;
        end
    end

    assign bus.o_mem_rw     = mem_rw_c;
    assign bus.o_mem_addr   = mem_addr_c;
    assign bus.o_mem_wdata  = mem_wdata_c;
    assign bus.o_ins_valid  = ins_valid_c;
    assign bus.o_ins_data   = fifo_data_q[rd_ptr_q];
    assign bus.o_ins_pc     = fifo_pc_q[rd_ptr_q];
    assign bus.o_dreq_ready = ~i_rst;
    assign bus.o_drsp_valid = drsp_valid_q;
    assign bus.o_drsp_data  = drsp_data_q;

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// Directed bench for mem_fetch_ctrl with a behavioural 256-word memory.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_mem_fetch_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_fetch_ctrl_if #(.BITS(16)) bus ();

    mem_fetch_ctrl #(
        .BITS(16),
        .FIFO_DEPTH(4),
        .RESET_PC(8'h00)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    // Memory: combinational read, write on rising edge
    logic [15:0] mem [256];
    assign bus.i_mem_rdata = mem[bus.o_mem_addr];
    always @(posedge clk) begin
        if (bus.o_mem_rw) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
    end

    function automatic logic [15:0] iw(input logic [7:0] a);
        case (a)
            8'd0:    iw = 16'd1;
            8'd1:    iw = 16'd2;
            8'd2:    iw = 16'd3;
            8'd3:    iw = 16'd6490;
            8'd4:    iw = 16'd4;
            default: iw = 16'hA000 | {8'h00, a};
        endcase
    endfunction

    typedef struct {
        logic        rst, rdy, jmp;
        logic [7:0]  jaddr;
        logic        dv, drw;
        logic [7:0]  daddr;
        logic [15:0] dwd;
        logic        chk_reg;
        logic        e_rw;
        logic [7:0]  e_addr;
        logic [15:0] e_wd;
        logic        e_dr;
        logic        e_iv;
        logic [7:0]  e_pc;
        logic [15:0] e_id;
        logic        e_sv;
        logic [15:0] e_sd;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic rd, input logic j, input logic [7:0] ja,
        input logic dv, input logic drw, input logic [7:0] da, input logic [15:0] dw,
        input logic ck, input logic erw, input logic [7:0] ea,
        input logic eiv, input logic [7:0] epc, input logic esv, input logic [15:0] esd);
        vec_t v;
        v.rst = r; v.rdy = rd; v.jmp = j; v.jaddr = ja;
        v.dv = dv; v.drw = drw; v.daddr = da; v.dwd = dw;
        v.chk_reg = ck; v.e_rw = erw; v.e_addr = ea;
        v.e_wd = (dv && drw && !r) ? dw : 16'h0000;
        v.e_dr = !r;
        v.e_iv = eiv; v.e_pc = epc; v.e_id = iw(epc);
        v.e_sv = esv; v.e_sd = esd;
        return v;
    endfunction

    vec_t vq[$];
    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic j, input logic [7:0] ja,
                         input logic dv, input logic drw, input logic [7:0] da, input logic [15:0] dw);
        @(negedge clk);
        rst              = r;
        bus.i_ins_ready  = rd;
        bus.i_jmp_valid  = j;
        bus.i_jmp_addr   = ja;
        bus.i_dreq_valid = dv;
        bus.i_dreq_rw    = drw;
        bus.i_dreq_addr  = da;
        bus.i_dreq_wdata = dw;
        #1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = iw(8'(a));
        rst = 1'b1;
        bus.i_ins_ready = 1'b0; bus.i_jmp_valid = 1'b0; bus.i_jmp_addr = 8'h00;
        bus.i_dreq_valid = 1'b0; bus.i_dreq_rw = 1'b0; bus.i_dreq_addr = 8'h00;
        bus.i_dreq_wdata = 16'h0000;

        //            rst rdy jmp jaddr  dv drw daddr dwd       ck rw addr  iv pc     sv sd
        vq.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0, 8'h00, 0, 16'h0000));
        vq.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 0, 8'h00, 0, 16'h0000));
        // Sequential stream from RESET_PC
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 0, 8'h00, 0, 16'h0000));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h01, 1, 8'h00, 0, 16'h0000));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h02, 1, 8'h01, 0, 16'h0000));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h03, 1, 8'h02, 0, 16'h0000));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h04, 1, 8'h03, 0, 16'h0000));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h05, 1, 8'h04, 0, 16'h0000));
        // Store then load of address 20
        vq.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'd20, 16'hBEEF, 1, 1, 8'd20,  1, 8'h05, 0, 16'h0000));
        vq.push_back(mk(0, 1, 0, 8'h00, 1, 0, 8'd20, 16'h0000, 1, 0, 8'd20,  0, 8'h00, 0, 16'h0000));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h06, 0, 8'h00, 1, 16'hBEEF));
        // Fill FIFO with pc 6..9 while decode stalls
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h07, 1, 8'h06, 0, 16'hBEEF));
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h08, 1, 8'h06, 0, 16'hBEEF));
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h09, 1, 8'h06, 0, 16'hBEEF));
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h0A, 1, 8'h06, 0, 16'hBEEF));
        // Redirect to 0xFE with ready high, then wrap through 0x00
        vq.push_back(mk(0, 1, 1, 8'hFE, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h0A, 1, 8'h06, 0, 16'hBEEF));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'hFE, 0, 8'h00, 0, 16'hBEEF));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'hFF, 1, 8'hFE, 0, 16'hBEEF));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 1, 8'hFF, 0, 16'hBEEF));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h01, 1, 8'h00, 0, 16'hBEEF));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h02, 1, 8'h01, 0, 16'hBEEF));
        // Redirect to 0x40 together with load of address 3
        vq.push_back(mk(0, 1, 1, 8'h40, 1, 0, 8'h03, 16'h0000, 1, 0, 8'h03, 1, 8'h02, 0, 16'hBEEF));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h40, 0, 8'h00, 1, 16'd6490));
        // Stall decode, issue a load, then reset mid-stream
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h41, 1, 8'h40, 0, 16'd6490));
        vq.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 1, 8'h40, 0, 16'd6490));
        vq.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h01, 16'h0000, 1, 0, 8'h00, 1, 8'h40, 1, 16'h0001));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 0, 8'h00, 0, 16'h0000));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h01, 1, 8'h00, 0, 16'h0000));
        vq.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h02, 1, 8'h01, 0, 16'h0000));

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            drive(v.rst, v.rdy, v.jmp, v.jaddr, v.dv, v.drw, v.daddr, v.dwd);
            n_vec++;
            chk("mem_rw",    i, 16'(bus.o_mem_rw),     16'(v.e_rw));
            chk("mem_addr",  i, 16'(bus.o_mem_addr),   16'(v.e_addr));
            chk("mem_wdata", i, bus.o_mem_wdata,       v.e_wd);
            chk("dreq_ready", i, 16'(bus.o_dreq_ready), 16'(v.e_dr));
            if (v.chk_reg) begin
                chk("ins_valid",  i, 16'(bus.o_ins_valid),  16'(v.e_iv));
                chk("drsp_valid", i, 16'(bus.o_drsp_valid), 16'(v.e_sv));
                chk("drsp_data",  i, bus.o_drsp_data,       v.e_sd);
                if (v.e_iv) begin
                    chk("ins_pc",   i, 16'(bus.o_ins_pc), 16'(v.e_pc));
                    chk("ins_data", i, bus.o_ins_data,    v.e_id);
                end
            end
        end

        // Stalled decode: exactly FIFO_DEPTH words fetched, then the port holds
        drive(1, 0, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
        drive(1, 0, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
        for (int k = 0; k < 7; k++) begin
            drive(0, 0, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
            n_vec++;
            chk("stall_addr",  100 + k, 16'(bus.o_mem_addr),  (k < 4) ? 16'(k) : 16'd4);
            chk("stall_valid", 100 + k, 16'(bus.o_ins_valid), (k > 0) ? 16'd1 : 16'd0);
            if (k > 0) chk("stall_pc", 100 + k, 16'(bus.o_ins_pc), 16'd0);
        end
        // Release: full FIFO with a pop accepts a new fetch in the same cycle
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
            n_vec++;
            chk("drain_valid", 200 + k, 16'(bus.o_ins_valid), 16'd1);
            chk("drain_pc",    200 + k, 16'(bus.o_ins_pc),    16'(k));
            chk("drain_data",  200 + k, bus.o_ins_data,       iw(8'(k)));
            chk("drain_addr",  200 + k, 16'(bus.o_mem_addr),  16'(k + 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
